// File: rtl/fpu_seq_ctrl_pkg.sv
// fpu_seq_ctrl_pkg: state encodings and FP opcode values shared by the FP sequencer files.
package fpu_seq_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;
  localparam logic FP_OP_ADD = 1'b0;
  localparam logic FP_OP_MUL = 1'b1;
endpackage

// File: rtl/fpu_step_counter.sv
// fpu_step_counter: loadable down-counter with zero flag, holds at zero instead of wrapping.
module fpu_step_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: multi-cycle FP add/mul sequencer (latch, exec, normalize, round); FPU_ZERO_BYPASS_EN adds an FMUL zero-operand shortcut.
module fpu_seq_ctrl
  import fpu_seq_ctrl_pkg::*;
#(
  parameter int MUL_CYC  = 3,
  parameter int NORM_MAX = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic Start,
  input  logic FpOp,
  input  logic OpAZero,
  input  logic OpBZero,
  input  logic NormDone,
  output logic Stall,
  output logic LatchOps,
  output logic ExecEn,
  output logic NormShift,
  output logic RoundEn,
  output logic ResultValid,
  output logic ZeroOut,
  output logic Exc
);
  localparam int CW = $clog2(MUL_CYC + 1);
  localparam int NW = $clog2(NORM_MAX + 1);
  state_t state;
  logic op_q, exc_q, rst_d, go, byp, cnt_zero;
  logic [CW-1:0] cnt;
  logic [NW-1:0] ncnt;
  // The first cycle after reset is held quiet, so a Start there is not accepted.
  assign go = state == S_IDLE && Start && !rst_d;
`ifdef FPU_ZERO_BYPASS_EN
  logic zero_q;
  assign byp = go && FpOp == FP_OP_MUL && (OpAZero || OpBZero);
  assign ZeroOut = ResultValid && zero_q;
  logic unused_ops;
  assign unused_ops = op_q;
`else
  assign byp = 1'b0;
  assign ZeroOut = 1'b0;
  logic unused_ops;
  assign unused_ops = ^{op_q, OpAZero, OpBZero};
`endif
  fpu_step_counter #(.W(CW)) u_exec_cnt (
    .clk(clk),
    .reset(reset),
    .load(go),
    .load_val(CW'((FpOp == FP_OP_MUL ? MUL_CYC : 1) - 1)),
    .dec(state == S_EXEC),
    .cnt(cnt),
    .zero(cnt_zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q <= 1'b0;
      exc_q <= 1'b0;
      ncnt <= '0;
      rst_d <= 1'b1;
`ifdef FPU_ZERO_BYPASS_EN
      zero_q <= 1'b0;
`endif
    end else begin
      rst_d <= 1'b0;
      case (state)
        S_IDLE: if (go) begin
          op_q <= FpOp;
          state <= byp ? S_DONE : S_EXEC;
`ifdef FPU_ZERO_BYPASS_EN
          zero_q <= byp;
`endif
        end
        S_EXEC: if (cnt_zero) begin
          state <= S_NORM;
          ncnt <= '0;
        end
        S_NORM:
          if (NormDone) state <= S_ROUND;
          else if (ncnt == NW'(NORM_MAX - 1)) begin
            exc_q <= 1'b1;
            state <= S_ROUND;
          end else ncnt <= ncnt + 1'b1;
        S_ROUND: state <= S_DONE;
        S_DONE: begin
          state <= S_IDLE;
          exc_q <= 1'b0;
`ifdef FPU_ZERO_BYPASS_EN
          zero_q <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign Stall = !reset && (state == S_IDLE ? go : state != S_DONE);
  assign LatchOps = !reset && go;
  assign ExecEn = !reset && state == S_EXEC;
  assign NormShift = !reset && state == S_NORM && !NormDone;
  assign RoundEn = !reset && state == S_ROUND;
  assign ResultValid = !reset && state == S_DONE;
  assign Exc = ResultValid && exc_q;
endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb_fpu_seq_ctrl: timeline model of the FP sequencer checked every cycle, plus literal latency checks.
module tb_fpu_seq_ctrl;
  localparam int MUL_CYC = 3;
  localparam int NORM_MAX = 24;
`ifdef FPU_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, Start = 1'b0, FpOp = 1'b0, OpAZero = 1'b0, OpBZero = 1'b0, NormDone = 1'b1;
  logic Stall, LatchOps, ExecEn, NormShift, RoundEn, ResultValid, ZeroOut, Exc;
  int tests = 0, fails = 0, cyc = 0;
  bit active = 0, byp = 0, prst = 1, mexc = 0;
  int t = 0, e = 0, nend = 0, nd_left = 0;
  int st_cyc = 0, rv_cnt = 0, lat = 0, shift_cnt = 0, exec_cnt = 0;
  bit last_exc = 0, last_zero = 0;

  fpu_seq_ctrl #(.MUL_CYC(MUL_CYC), .NORM_MAX(NORM_MAX)) dut (
    .clk(clk), .reset(reset), .Start(Start), .FpOp(FpOp), .OpAZero(OpAZero), .OpBZero(OpBZero),
    .NormDone(NormDone), .Stall(Stall), .LatchOps(LatchOps), .ExecEn(ExecEn), .NormShift(NormShift),
    .RoundEn(RoundEn), .ResultValid(ResultValid), .ZeroOut(ZeroOut), .Exc(Exc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic bit in_norm();
    return active && !byp && t > e && nend == 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: operation viewed as a timeline t = cycles since the accepting IDLE cycle.
  always @(negedge clk) begin
    logic [7:0] exp_v, act_v;
    bit done, ex, nm, rd, acc;
    act_v = {Stall, LatchOps, ExecEn, NormShift, RoundEn, ResultValid, ZeroOut, Exc};
    exp_v = '0;
    if (reset) begin
      active = 0;
      prst = 1;
    end else begin
      acc = !active && Start && !prst;
      if (active) begin
        done = byp ? t == 1 : (nend != 0 && t == nend + 1);
        ex = !byp && t <= e;
        nm = in_norm();
        rd = !byp && nend != 0 && t == nend;
        exp_v = {!done, 1'b0, ex, nm && !NormDone, rd, done, done && byp, done && mexc};
        if (nm && !NormDone && nd_left > 0) nd_left--;
        if (nm && (NormDone || t - e - 1 == NORM_MAX - 1)) begin
          nend = t + 1;
          mexc = !NormDone;
        end
        if (done) active = 0;
        else t++;
      end else if (acc) begin
        exp_v = 8'b1100_0000;
        active = 1;
        t = 1;
        e = FpOp ? MUL_CYC : 1;
        nend = 0;
        mexc = 0;
        byp = BYP && FpOp && (OpAZero || OpBZero);
        st_cyc = cyc;
        shift_cnt = 0;
        exec_cnt = 0;
      end
      prst = 0;
    end
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL outputs cycle %0d: got %b expected %b (Stall,LatchOps,ExecEn,NormShift,RoundEn,ResultValid,ZeroOut,Exc)", cyc, act_v, exp_v);
    end
    if (ResultValid === 1'b1) begin
      rv_cnt++;
      lat = cyc - st_cyc;
      last_exc = Exc;
      last_zero = ZeroOut;
    end
    if (NormShift === 1'b1) shift_cnt++;
    if (ExecEn === 1'b1) exec_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    NormDone = !(in_norm() && nd_left > 0);
  endtask

  task automatic run_op(input string name, input bit op, input bit az, input bit bz, input int nd,
                        input int x_lat, input int x_exc, input int x_zero, input int x_shift, input int x_exec);
    int base;
    base = rv_cnt;
    nd_left = nd;
    FpOp = op; OpAZero = az; OpBZero = bz; Start = 1'b1;
    step();
    Start = 1'b0; FpOp = 1'b0; OpAZero = 1'b0; OpBZero = 1'b0;
    for (int i = 0; i < 200 && rv_cnt == base; i++) step();
    check({name, " completed"}, rv_cnt - base, 1);
    check({name, " latency"}, lat, x_lat);
    check({name, " Exc"}, last_exc, x_exc);
    check({name, " ZeroOut"}, last_zero, x_zero);
    check({name, " shifts"}, shift_cnt, x_shift);
    check({name, " exec cycles"}, exec_cnt, x_exec);
    step();
  endtask

  initial begin
    int base;
    step(); step();
    reset = 1'b0;
    step(); step();
    run_op("fadd", 0, 0, 0, 0, 4, 0, 0, 0, 1);
    run_op("fmul", 1, 0, 0, 0, 3 + MUL_CYC, 0, 0, 0, MUL_CYC);
    run_op("fadd 2 shifts", 0, 0, 0, 2, 6, 0, 0, 2, 1);
    run_op("fadd timeout", 0, 0, 0, 1000, 27, 1, 0, NORM_MAX, 1);
    run_op("fadd after timeout", 0, 0, 0, 0, 4, 0, 0, 0, 1);
    run_op("fmul zero b", 1, 0, 1, 0, BYP ? 1 : 6, 0, BYP ? 1 : 0, 0, BYP ? 0 : MUL_CYC);
    run_op("fadd zero a", 0, 1, 0, 0, 4, 0, 0, 0, 1);
    // Start held high: second op starts the cycle after DONE.
    base = rv_cnt;
    Start = 1'b1;
    for (int i = 0; i < 50 && rv_cnt < base + 2; i++) step();
    Start = 1'b0;
    check("back-to-back count", rv_cnt - base, 2);
    check("back-to-back latency", lat, 4);
    step(); step();
    // Reset two cycles into an FMUL aborts it.
    base = rv_cnt;
    FpOp = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0; FpOp = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("reset abort no result", rv_cnt - base, 0);
    run_op("fmul after reset", 1, 0, 0, 0, 6, 0, 0, 0, MUL_CYC);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
